// File: rtl/uart_rx_fifo_pkg.sv
// Shared UART constants: character width used by the receiver, the RX FIFO and
// the future transmitter, plus the default FIFO depth exponent.
package uart_rx_fifo_pkg;

  // Character width of the UART datapath.
  localparam int unsigned BITWIDTH = 8;

  // Default FIFO depth exponent (depth = 2**FIFO_ADDR_WIDTH).
  localparam int unsigned FIFO_ADDR_WIDTH = 4;

  // Status flags of a circular FIFO, grouped for internal bookkeeping.
  typedef struct packed {
    logic empty;
    logic full;
    logic overrun;
  } fifo_flags_t;

  // Reset value of the status flags.
  localparam fifo_flags_t FIFO_FLAGS_RST = '{empty: 1'b1, full: 1'b0, overrun: 1'b0};

endpackage : uart_rx_fifo_pkg

// File: rtl/uart_fifo_mem.sv
// Simple dual-port register array for the UART FIFOs.
// Synchronous write port, asynchronous (combinational) read port. Not reset.
// Ports:
//   clk        - write clock
//   wr_en_i    - write enable
//   wr_addr_i  - write address
//   wr_data_i  - write data
//   rd_addr_i  - read address
//   rd_data_o  - read data (combinational from rd_addr_i)
module uart_fifo_mem
  import uart_rx_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = BITWIDTH,
  parameter int unsigned ADDR_WIDTH = FIFO_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  wr_en_i,
  input  logic [ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  output logic [DATA_WIDTH-1:0] rd_data_o
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Write port: storage is intentionally left unreset.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Read port: combinational so the head byte falls through.
  assign rd_data_o = mem_q[rd_addr_i];

endmodule : uart_fifo_mem

// File: rtl/uart_rx_fifo.sv
// UART receive FIFO: captures bytes from the receiver on wr_tick, presents them
// first-word-fall-through to the host, and flags dropped bytes as overrun.
// Ports:
//   clk         - system clock, rising edge
//   reset       - asynchronous active-high reset
//   wr_tick     - write strobe (receiver rx_done_tick)
//   wr_data     - byte to store (receiver rx_dout)
//   rd_en       - pop strobe, ignored while empty
//   clr_overrun - clears the sticky overrun flag
//   rd_data     - head-of-FIFO byte, valid while empty=0
//   empty       - no entries held
//   full        - 2**ADDR_WIDTH entries held
//   count       - occupancy 0..2**ADDR_WIDTH
//   overrun     - sticky, set when a write was dropped
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = BITWIDTH,
  parameter int unsigned ADDR_WIDTH = FIFO_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_tick,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic                  clr_overrun,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  empty,
  output logic                  full,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overrun
);

  // Pointer width: address bits plus one wrap bit.
  localparam int unsigned PTR_W = ADDR_WIDTH + 1;

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  count_q, count_d;
  fifo_flags_t       flags_q, flags_d;

  logic do_rd_c;
  logic do_wr_c;
  logic drop_c;

  // Effective strobes from current state; a read at full frees the slot
  // that the same-cycle write reuses.
  always_comb begin
    do_rd_c = rd_en & ~flags_q.empty;
    do_wr_c = wr_tick & (~flags_q.full | do_rd_c);
    drop_c  = wr_tick & flags_q.full & ~do_rd_c;
  end

  // Next-state: pointers advance on effective strobes; status flags and
  // count are computed from the next pointers so they are registered.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    flags_d  = flags_q;
    count_d  = count_q;

    if (do_wr_c) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (do_rd_c) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    flags_d.empty = (wr_ptr_d == rd_ptr_d);
    flags_d.full  = (wr_ptr_d[ADDR_WIDTH-1:0] == rd_ptr_d[ADDR_WIDTH-1:0]) &&
                    (wr_ptr_d[ADDR_WIDTH] != rd_ptr_d[ADDR_WIDTH]);
    count_d       = wr_ptr_d - rd_ptr_d;

    // A new drop takes priority over a same-cycle clear.
    if (drop_c) begin
      flags_d.overrun = 1'b1;
    end else if (clr_overrun) begin
      flags_d.overrun = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      flags_q  <= FIFO_FLAGS_RST;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      flags_q  <= flags_d;
    end
  end

  uart_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk       (clk),
    .wr_en_i   (do_wr_c),
    .wr_addr_i (wr_ptr_q[ADDR_WIDTH-1:0]),
    .wr_data_i (wr_data),
    .rd_addr_i (rd_ptr_q[ADDR_WIDTH-1:0]),
    .rd_data_o (rd_data)
  );

  assign empty   = flags_q.empty;
  assign full    = flags_q.full;
  assign overrun = flags_q.overrun;
  assign count   = count_q;

endmodule : uart_rx_fifo

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo.
module tb_uart_rx_fifo;

  logic       clk;
  logic       reset;
  logic       wr_tick;
  logic [7:0] wr_data;
  logic       rd_en;
  logic       clr_overrun;
  logic [7:0] rd_data;
  logic       empty;
  logic       full;
  logic [4:0] count;
  logic       overrun;

  int total;
  int bad;

  uart_rx_fifo dut (
    .clk         (clk),
    .reset       (reset),
    .wr_tick     (wr_tick),
    .wr_data     (wr_data),
    .rd_en       (rd_en),
    .clr_overrun (clr_overrun),
    .rd_data     (rd_data),
    .empty       (empty),
    .full        (full),
    .count       (count),
    .overrun     (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; sample 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    wr_tick = 1'b1;
    wr_data = d;
    step();
    wr_tick = 1'b0;
  endtask

  task automatic pop_chk(input string tag, input logic [7:0] exp);
    chk(tag, 32'(rd_data), 32'(exp));
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
  endtask

  logic [7:0] q[$];
  logic [7:0] b;

  initial begin
    total = 0;
    bad = 0;
    reset = 1'b1;
    wr_tick = 1'b0;
    wr_data = 8'h00;
    rd_en = 1'b0;
    clr_overrun = 1'b0;
    step();
    step();
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    reset = 1'b0;
    step();

    // Fill and drain three bytes.
    push(8'h41);
    chk("t1_empty1", 32'(empty), 32'd0);
    chk("t1_head1", 32'(rd_data), 32'h41);
    chk("t1_cnt1", 32'(count), 32'd1);
    push(8'h42);
    chk("t1_cnt2", 32'(count), 32'd2);
    chk("t1_head2", 32'(rd_data), 32'h41);
    push(8'h43);
    chk("t1_cnt3", 32'(count), 32'd3);
    pop_chk("t1_rd0", 8'h41);
    chk("t1_cnt_after_rd", 32'(count), 32'd2);
    pop_chk("t1_rd1", 8'h42);
    pop_chk("t1_rd2", 8'h43);
    chk("t1_empty_end", 32'(empty), 32'd1);
    chk("t1_cnt_end", 32'(count), 32'd0);

    // Read while empty is ignored.
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    chk("rd_empty_cnt", 32'(count), 32'd0);
    chk("rd_empty_flag", 32'(empty), 32'd1);
    chk("rd_empty_ovr", 32'(overrun), 32'd0);

    // Fill to full, then overrun.
    for (int i = 0; i < 16; i++) begin
      push(8'(i));
    end
    chk("t2_full", 32'(full), 32'd1);
    chk("t2_cnt16", 32'(count), 32'd16);
    chk("t2_ovr0", 32'(overrun), 32'd0);
    push(8'hAA);
    chk("t2_ovr1", 32'(overrun), 32'd1);
    chk("t2_cnt_drop", 32'(count), 32'd16);
    chk("t2_head_drop", 32'(rd_data), 32'h00);

    // Clear together with a new drop: set wins.
    clr_overrun = 1'b1;
    wr_tick = 1'b1;
    wr_data = 8'hBB;
    step();
    clr_overrun = 1'b0;
    wr_tick = 1'b0;
    chk("t5_ovr_set_wins", 32'(overrun), 32'd1);
    chk("t5_cnt", 32'(count), 32'd16);
    clr_overrun = 1'b1;
    step();
    clr_overrun = 1'b0;
    chk("t5_ovr_clr", 32'(overrun), 32'd0);

    // Drain: 0x00..0x0F only.
    for (int i = 0; i < 16; i++) begin
      pop_chk($sformatf("t2_drain%0d", i), 8'(i));
      chk($sformatf("t2_drain_full%0d", i), 32'(full), 32'd0);
    end
    chk("t2_empty_end", 32'(empty), 32'd1);

    // Simultaneous read and write at full.
    for (int i = 0; i < 16; i++) begin
      push(8'(i));
    end
    chk("t3_full_pre", 32'(full), 32'd1);
    wr_tick = 1'b1;
    wr_data = 8'h55;
    rd_en = 1'b1;
    step();
    wr_tick = 1'b0;
    rd_en = 1'b0;
    chk("t3_cnt", 32'(count), 32'd16);
    chk("t3_full", 32'(full), 32'd1);
    chk("t3_ovr", 32'(overrun), 32'd0);
    for (int i = 1; i < 16; i++) begin
      pop_chk($sformatf("t3_drain%0d", i), 8'(i));
    end
    pop_chk("t3_last", 8'h55);
    chk("t3_empty_end", 32'(empty), 32'd1);

    // Simultaneous read and write at empty.
    wr_tick = 1'b1;
    wr_data = 8'h7E;
    rd_en = 1'b1;
    step();
    wr_tick = 1'b0;
    rd_en = 1'b0;
    chk("t4_cnt", 32'(count), 32'd1);
    chk("t4_empty", 32'(empty), 32'd0);
    chk("t4_head", 32'(rd_data), 32'h7E);
    pop_chk("t4_pop", 8'h7E);
    chk("t4_empty_end", 32'(empty), 32'd1);

    // Wrap: 40 bytes with occupancy kept at or below 4.
    q.delete();
    for (int i = 0; i < 40; i++) begin
      b = 8'(i * 7 + 3);
      push(b);
      q.push_back(b);
      chk($sformatf("t6_cnt%0d", i), 32'(count), 32'(q.size()));
      chk($sformatf("t6_nofull%0d", i), 32'(full), 32'd0);
      chk($sformatf("t6_noempty%0d", i), 32'(empty), 32'd0);
      if (q.size() == 4) begin
        for (int k = 0; k < 3; k++) begin
          pop_chk($sformatf("t6_rd%0d_%0d", i, k), q.pop_front());
        end
      end
    end
    while (q.size() > 0) begin
      pop_chk("t6_tail", q.pop_front());
    end
    chk("t6_empty_end", 32'(empty), 32'd1);

    // Async reset with 3 bytes queued and overrun set.
    for (int i = 0; i < 16; i++) begin
      push(8'(8'hC0 + 8'(i)));
    end
    push(8'hEE);
    chk("t7_ovr_pre", 32'(overrun), 32'd1);
    for (int i = 0; i < 13; i++) begin
      pop_chk($sformatf("t7_pop%0d", i), 8'(8'hC0 + 8'(i)));
    end
    chk("t7_cnt_pre", 32'(count), 32'd3);
    #2;
    reset = 1'b1;
    #1;
    chk("t7_async_empty", 32'(empty), 32'd1);
    chk("t7_async_cnt", 32'(count), 32'd0);
    chk("t7_async_ovr", 32'(overrun), 32'd0);
    chk("t7_async_full", 32'(full), 32'd0);
    step();
    reset = 1'b0;
    step();
    chk("t7_post_empty", 32'(empty), 32'd1);
    push(8'h99);
    chk("t7_post_head", 32'(rd_data), 32'h99);
    chk("t7_post_cnt", 32'(count), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_uart_rx_fifo
